// File: rtl/dmem_lat.sv
// Word-addressed data RAM with byte-lane writes, a fixed access latency and a
// critical-word-first burst read, intended as a slow main-memory model.
module dmem_lat #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 128,
   parameter int ADDR_W    = 32,
   parameter int LATENCY   = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                ReqValid,
   output logic                ReqReady,
   input  logic                ReqWrite,
   input  logic                ReqBurst,
   input  logic [ADDR_W-1:0]   Address,
   input  logic [DATA_W-1:0]   WriteData,
   input  logic [DATA_W/8-1:0] ByteEn,
   output logic                RespValid,
   output logic [DATA_W-1:0]   RespData,
   output logic                RespLast,
   output logic                Busy
);

   localparam int NBYTES = DATA_W / 8;
   localparam int OFF_W  = (NBYTES > 1) ? $clog2(NBYTES) : 0;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [IDX_W-1:0] BMASK     = IDX_W'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state;
   logic                run;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    beat;
   logic [IDX_W-1:0]    idx;
   logic                wr;
   logic                bst;
   logic [DATA_W-1:0]   wdata;
   logic [NBYTES-1:0]   be;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                accept;
   logic                commit;
   logic                first_last;
   logic [IDX_W-1:0]    req_idx;
   logic [IDX_W-1:0]    nxt_beat;
   logic [IDX_W-1:0]    rd_idx;
   logic [DATA_W-1:0]   rd_word;
   logic                unused_addr;

   // run holds ReqReady low until the first edge after reset is released
   assign ReqReady = (state == IDLE) && run;
   assign Busy     = (state != IDLE);
   assign accept   = ReqValid && ReqReady;
   assign req_idx  = Address[OFF_W +: IDX_W];
   assign unused_addr = ^Address;

   // writes land on the edge that enters RESP, so a reset in WAIT drops them
   assign commit     = (state == WAIT) && (cnt == '0) && wr;
   assign first_last = wr || !bst || (BURST_LEN == 1);

   // beat 0 is fetched while leaving WAIT, later beats while in RESP
   assign nxt_beat = (state == RESP) ? beat + 1'b1 : '0;
   assign rd_idx   = (idx & ~BMASK) | ((idx + nxt_beat) & BMASK);
   assign rd_word  = mem[rd_idx];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         run       <= 1'b0;
         cnt       <= '0;
         beat      <= '0;
         idx       <= '0;
         wr        <= 1'b0;
         bst       <= 1'b0;
         wdata     <= '0;
         be        <= '0;
         RespValid <= 1'b0;
         RespLast  <= 1'b0;
         RespData  <= '0;
      end else begin
         run <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  idx   <= req_idx;
                  wr    <= ReqWrite;
                  bst   <= ReqBurst && !ReqWrite;
                  wdata <= WriteData;
                  be    <= ByteEn;
                  cnt   <= CNT_INIT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  beat      <= '0;
                  RespValid <= 1'b1;
                  RespLast  <= first_last;
                  RespData  <= wr ? '0 : rd_word;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               // RespLast doubles as "this beat is the final one"
               if (RespLast) begin
                  state     <= IDLE;
                  RespValid <= 1'b0;
                  RespLast  <= 1'b0;
                  RespData  <= '0;
               end else begin
                  beat     <= nxt_beat;
                  RespLast <= (nxt_beat == LAST_BEAT);
                  RespData <= rd_word;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // storage has no reset; contents survive RST
   always_ff @(posedge CLK) begin
      if (commit) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_lat.sv
// Directed bench for dmem_lat at default parameters (32-bit, 128 words,
// latency 4, burst 4).
module tb_dmem_lat;

   logic        CLK;
   logic        RST;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic        ReqBurst;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [3:0]  ByteEn;
   logic        RespValid;
   logic [31:0] RespData;
   logic        RespLast;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   dmem_lat dut (
      .CLK(CLK), .RST(RST),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqBurst(ReqBurst), .Address(Address), .WriteData(WriteData),
      .ByteEn(ByteEn), .RespValid(RespValid), .RespData(RespData),
      .RespLast(RespLast), .Busy(Busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Presents a request and returns one edge after it is accepted.
   task automatic issue(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] e, output logic ok);
      ok = 1'b0;
      ReqValid = 1'b1; ReqWrite = w; ReqBurst = b;
      Address = a; WriteData = d; ByteEn = e;
      for (int i = 0; i < 40; i++) begin
         if (ReqReady) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (ok) step();
      ReqValid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] e, output logic ok);
      issue(1'b1, 1'b0, a, d, e, ok);
      repeat (4) step();
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic ok);
      issue(1'b0, 1'b0, a, 32'h0, 4'h0, ok);
      repeat (4) step();
      d = RespData;
   endtask

   task automatic test_reset();
      RST = 1'b0; ReqValid = 1'b1; ReqWrite = 1'b0; ReqBurst = 1'b0;
      Address = 32'h0; WriteData = 32'h0; ByteEn = 4'h0;
      repeat (3) step();
      checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL reset_respvalid got %b want 0", RespValid); end
      checks++; if (RespData !== 32'h0) begin errors++; $display("FAIL reset_respdata got %h want 0", RespData); end
      checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL reset_reqready got %b want 0", ReqReady); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
      RST = 1'b1;
      step();
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL release_reqready got %b want 1", ReqReady); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", Busy); end
      ReqValid = 1'b0;
   endtask

   task automatic test_byte_en();
      logic ok;
      logic [31:0] d;
      issue(1'b1, 1'b0, 32'h10, 32'hAABBCCDD, 4'b1111, ok);
      checks++; if (!ok) begin errors++; $display("FAIL be_accept1 got timeout want accept"); end
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 3) begin
            checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL be_ack1_early got %b want 0", RespValid); end
         end
      end
      checks++; if ({RespValid, RespLast} !== 2'b11) begin errors++; $display("FAIL be_ack1 valid/last got %b want 11", {RespValid, RespLast}); end
      checks++; if (RespData !== 32'h0) begin errors++; $display("FAIL be_ack1_data got %h want 0", RespData); end
      checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL be_ack1_ready got %b want 0", ReqReady); end

      issue(1'b1, 1'b0, 32'h10, 32'h11223344, 4'b0101, ok);
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 3) begin
            checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL be_ack2_early got %b want 0", RespValid); end
         end
      end
      checks++; if ({RespValid, RespLast} !== 2'b11) begin errors++; $display("FAIL be_ack2 valid/last got %b want 11", {RespValid, RespLast}); end

      do_read(32'h10, d, ok);
      checks++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL be_read got %h want aa22cc44", d); end
      checks++; if ({RespValid, RespLast} !== 2'b11) begin errors++; $display("FAIL be_read valid/last got %b want 11", {RespValid, RespLast}); end
   endtask

   task automatic test_burst_wrap();
      logic ok;
      logic [31:0] exp_d [4];
      exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'h8; exp_d[3] = 32'h9;
      for (int w = 0; w < 4; w++) do_write(32'h20 + 32'(w * 4), 32'(8 + w), 4'hF, ok);
      issue(1'b0, 1'b1, 32'h28, 32'h0, 4'h0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL burst_accept got timeout want accept"); end
      repeat (3) step();
      checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL burst_early got %b want 0", RespValid); end
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (RespValid !== 1'b1) begin errors++; $display("FAIL burst_valid beat %0d got %b want 1", k, RespValid); end
         checks++; if (RespData !== exp_d[k]) begin errors++; $display("FAIL burst_data beat %0d got %h want %h", k, RespData, exp_d[k]); end
         checks++; if (RespLast !== (k == 3)) begin errors++; $display("FAIL burst_last beat %0d got %b want %b", k, RespLast, (k == 3)); end
         checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL burst_ready beat %0d got %b want 0", k, ReqReady); end
      end
      step();
      checks++; if ({RespValid, Busy} !== 2'b00) begin errors++; $display("FAIL burst_end valid/busy got %b want 00", {RespValid, Busy}); end
   endtask

   task automatic test_busy_ignore();
      logic ok = 1'b0;
      int nb = 0;
      int bc [2];
      logic [31:0] bd [2];
      bc[0] = 0; bc[1] = 0; bd[0] = 32'h0; bd[1] = 32'h0;
      ReqValid = 1'b1; ReqWrite = 1'b0; ReqBurst = 1'b0; Address = 32'h10;
      for (int i = 0; i < 40; i++) begin
         if (ReqReady) begin ok = 1'b1; break; end
         step();
      end
      checks++; if (!ok) begin errors++; $display("FAIL busy_accept got timeout want accept"); end
      step();
      for (int c = 1; c <= 12; c++) begin
         step();
         if (RespValid) begin
            if (nb < 2) begin bc[nb] = c; bd[nb] = RespData; end
            nb++;
         end
         if (c < 4) Address = 32'h100 + 32'(c * 4);
         if (c == 3) begin
            checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy_wait got %b want 1", Busy); end
         end
         if (c == 4) begin
            checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL busy_resp_ready got %b want 0", ReqReady); end
         end
         if (c == 5) begin
            checks++; if ({ReqReady, Busy} !== 2'b10) begin errors++; $display("FAIL busy_idle ready/busy got %b want 10", {ReqReady, Busy}); end
            Address = 32'h2C;
         end
         if (c == 6) ReqValid = 1'b0;
      end
      checks++; if (nb != 2) begin errors++; $display("FAIL busy_beats got %0d want 2", nb); end
      checks++; if (bc[0] != 4 || bd[0] !== 32'hAA22CC44) begin errors++; $display("FAIL busy_first got cyc %0d data %h want cyc 4 data aa22cc44", bc[0], bd[0]); end
      checks++; if (bc[1] != 10 || bd[1] !== 32'hB) begin errors++; $display("FAIL busy_second got cyc %0d data %h want cyc 10 data b", bc[1], bd[1]); end
   endtask

   task automatic test_addr_wrap();
      logic ok;
      logic [31:0] d;
      do_write(32'h200, 32'h5A5A5A5A, 4'hF, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_write got timeout want accept"); end
      do_read(32'h0, d, ok);
      checks++; if (d !== 32'h5A5A5A5A) begin errors++; $display("FAIL wrap_read0 got %h want 5a5a5a5a", d); end
      do_read(32'h8000_0010, d, ok);
      checks++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL wrap_readhi got %h want aa22cc44", d); end
   endtask

   task automatic test_reset_mid();
      logic ok;
      logic [31:0] d;
      int extra = 0;
      issue(1'b0, 1'b1, 32'h28, 32'h0, 4'h0, ok);
      repeat (5) step();
      checks++; if (RespValid !== 1'b1 || RespData !== 32'hB) begin errors++; $display("FAIL midrst_beat2 got valid %b data %h want 1 b", RespValid, RespData); end
      #3 RST = 1'b0;
      #1;
      checks++; if ({RespValid, Busy} !== 2'b00) begin errors++; $display("FAIL midrst_drop valid/busy got %b want 00", {RespValid, Busy}); end
      repeat (3) begin
         step();
         if (RespValid) extra++;
      end
      RST = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         if (RespValid) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL midrst_extra_beats got %0d want 0", extra); end

      issue(1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 4'hF, ok);
      step();
      RST = 1'b0;
      step();
      RST = 1'b1;
      do_read(32'h20, d, ok);
      checks++; if (!ok) begin errors++; $display("FAIL waitrst_accept got timeout want accept"); end
      checks++; if (d !== 32'h8) begin errors++; $display("FAIL waitrst_read got %h want 8", d); end
   endtask

   initial begin
      test_reset();
      test_byte_en();
      test_burst_wrap();
      test_busy_ignore();
      test_addr_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
